// File: rtl/exp_stream_pkg.sv
// exp_stream_pkg: shared definitions for the exponent stream store.
//   - default geometry matching the ModExp globals
//   - FSM state encoding
//   - helpers for RAM read latency and bit-index counter width
package exp_stream_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_NUM_WORDS  = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // Cycles from read issue to data on the RAM output.
  function automatic int read_lat(input int out_reg);
    return 1 + out_reg;
  endfunction

  // Width of the bit-index counter inside one word.
  function automatic int bit_idx_w(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/exp_word_ram.sv
// exp_word_ram: inferred simple dual-port RAM (1 write, 1 read port).
//   clock        single clock, rising edge
//   we/waddr/wdata  write port
//   re/raddr     read issue; data appears on rdata after 1 (OUT_REG=0)
//                or 2 (OUT_REG=1) cycles and holds until the next read
//   rdata        read data
// The array carries no reset; contents survive a design reset.
module exp_word_ram
  import exp_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int OUT_REG    = 1
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rd_q <= mem[raddr];
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] out_q;
      always_ff @(posedge clock) out_q <= rd_q;
      assign rdata = out_q;
    end else begin : g_noreg
      assign rdata = rd_q;
    end
  endgenerate

endmodule

// File: rtl/exp_stream_mem.sv
// exp_stream_mem: runtime-loadable exponent store that streams its bits
// MSB-first (word NUM_WORDS-1 first, word 0 last) over valid/ready.
//   clock, reset_n          clock / async active-low reset
//   wr_en, wr_addr, wr_data host write port, honoured only while idle
//   wr_reject               pulse: a write arrived while busy and was dropped
//   start                   begin a scan (ignored unless idle)
//   busy                    scan in progress
//   bit_valid/out/last      bit stream; bit_last marks bit 0 of word 0
//   bit_ready               consumer accept
//   done                    pulse the cycle after the final transfer
//   zero_exp                exponent was all-zero (SKIP_LZ=1), held to next start
// A one-word prefetch buffer keeps the stream gap-free across word
// boundaries: the next read is issued as soon as the buffer is empty and no
// read is in flight, so it lands well before the current word drains.
module exp_stream_mem
  import exp_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_WORDS  = DEF_NUM_WORDS,
  parameter int OUT_REG    = 1,
  parameter int SKIP_LZ    = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_reject,
  input  logic                  start,
  output logic                  busy,
  output logic                  bit_valid,
  output logic                  bit_out,
  output logic                  bit_last,
  input  logic                  bit_ready,
  output logic                  done,
  output logic                  zero_exp
);

  localparam int RL = read_lat(OUT_REG);
  localparam int BW = bit_idx_w(DATA_WIDTH);
  localparam int CW = $clog2(NUM_WORDS + 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;          // word being streamed
  logic [DATA_WIDTH-1:0] pf_q, pf_d;          // prefetched next word
  logic                  pf_vld_q, pf_vld_d;
  logic                  pf_w0_q, pf_w0_d;
  logic                  cur_w0_q, cur_w0_d;  // shift word is word 0
  logic                  found_q, found_d;    // first 1 already emitted
  logic [BW-1:0]         idx_q, idx_d;        // bits left in word minus one
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0]         rd_left_q, rd_left_d;
  logic [RL:1]           vld_pipe_q, vld_pipe_d;  // read-in-flight tracker
  logic [RL:1]           w0_pipe_q, w0_pipe_d;
  logic                  wr_reject_q, wr_reject_d;
  logic                  zero_exp_q, zero_exp_d;

  logic                  busy_c, rd_issue, need_word, arrive, arrive_w0;
  logic                  valid_c;
  logic [DATA_WIDTH-1:0] ram_rdata;

  exp_word_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_ram (
    .clock (clock),
    .we    (wr_en && !busy_c),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_issue),
    .raddr (rd_addr_q),
    .rdata (ram_rdata)
  );

  assign busy_c    = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_SHIFT);
  assign arrive    = vld_pipe_q[RL];
  assign arrive_w0 = w0_pipe_q[RL];
  // Before the first 1 is found a leading-zero bit is consumed internally.
  assign valid_c   = (state_q == ST_SHIFT) && (found_q || sh_q[DATA_WIDTH-1]);

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    pf_d        = pf_q;
    pf_vld_d    = pf_vld_q;
    pf_w0_d     = pf_w0_q;
    cur_w0_d    = cur_w0_q;
    found_d     = found_q;
    idx_d       = idx_q;
    rd_addr_d   = rd_addr_q;
    rd_left_d   = rd_left_q;
    zero_exp_d  = zero_exp_q;
    wr_reject_d = wr_en && busy_c;
    need_word   = 1'b0;
    rd_issue    = 1'b0;

    // One read outstanding at most, and only into an empty buffer.
    if (busy_c && rd_left_q != '0 && vld_pipe_q == '0 && !pf_vld_q) begin
      rd_issue  = 1'b1;
      rd_addr_d = rd_addr_q - ADDR_WIDTH'(1);
      rd_left_d = rd_left_q - CW'(1);
    end
    vld_pipe_d[1] = rd_issue;
    w0_pipe_d[1]  = (rd_left_q == CW'(1));
    for (int k = 2; k <= RL; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      w0_pipe_d[k]  = w0_pipe_q[k-1];
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_FETCH;
          rd_addr_d  = ADDR_WIDTH'(NUM_WORDS - 1);
          rd_left_d  = CW'(NUM_WORDS);
          found_d    = (SKIP_LZ == 0);
          zero_exp_d = 1'b0;
          pf_vld_d   = 1'b0;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  need_word = 1'b1;
      ST_SHIFT: begin
        if (SKIP_LZ != 0 && !found_q && sh_q == '0) begin
          // Whole word is leading zeros: drop it in one cycle.
          if (cur_w0_q) begin
            state_d    = ST_DONE;
            zero_exp_d = 1'b1;
          end else begin
            need_word = 1'b1;
          end
        end else if (!valid_c) begin
          sh_d  = sh_q << 1;
          idx_d = idx_q - BW'(1);
        end else if (bit_ready) begin
          found_d = 1'b1;
          sh_d    = sh_q << 1;
          idx_d   = idx_q - BW'(1);
          if (idx_q == '0) begin
            if (cur_w0_q) state_d = ST_DONE;
            else          need_word = 1'b1;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Refill the shift register from the buffer, or straight from the RAM
    // when the word lands in the very cycle it is needed.
    if (need_word) begin
      if (pf_vld_q) begin
        sh_d     = pf_q;
        cur_w0_d = pf_w0_q;
        idx_d    = BW'(DATA_WIDTH - 1);
        pf_vld_d = 1'b0;
        state_d  = ST_SHIFT;
      end else if (arrive) begin
        sh_d     = ram_rdata;
        cur_w0_d = arrive_w0;
        idx_d    = BW'(DATA_WIDTH - 1);
        state_d  = ST_SHIFT;
      end else begin
        state_d  = ST_WAIT;
      end
    end else if (arrive && busy_c) begin
      pf_d     = ram_rdata;
      pf_w0_d  = arrive_w0;
      pf_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      pf_q        <= '0;
      pf_vld_q    <= 1'b0;
      pf_w0_q     <= 1'b0;
      cur_w0_q    <= 1'b0;
      found_q     <= 1'b0;
      idx_q       <= '0;
      rd_addr_q   <= '0;
      rd_left_q   <= '0;
      vld_pipe_q  <= '0;
      w0_pipe_q   <= '0;
      wr_reject_q <= 1'b0;
      zero_exp_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      pf_q        <= pf_d;
      pf_vld_q    <= pf_vld_d;
      pf_w0_q     <= pf_w0_d;
      cur_w0_q    <= cur_w0_d;
      found_q     <= found_d;
      idx_q       <= idx_d;
      rd_addr_q   <= rd_addr_d;
      rd_left_q   <= rd_left_d;
      vld_pipe_q  <= vld_pipe_d;
      w0_pipe_q   <= w0_pipe_d;
      wr_reject_q <= wr_reject_d;
      zero_exp_q  <= zero_exp_d;
    end
  end

  assign busy      = busy_c;
  assign done      = (state_q == ST_DONE);
  assign bit_valid = valid_c;
  assign bit_out   = valid_c && sh_q[DATA_WIDTH-1];
  assign bit_last  = valid_c && cur_w0_q && (idx_q == '0);
  assign wr_reject = wr_reject_q;
  assign zero_exp  = zero_exp_q;

endmodule

// File: tb/tb_exp_stream_mem.sv
// Directed bench for exp_stream_mem: two instances share stimulus,
// dut_s (OUT_REG=1, SKIP_LZ=1) and dut_n (OUT_REG=0, SKIP_LZ=0); sel picks
// which one the scenario observes.
module tb_exp_stream_mem;

  logic       clock = 1'b0, reset_n = 1'b0;
  logic       wr_en = 1'b0, start = 1'b0, bit_ready = 1'b1;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic s_rej, s_busy, s_valid, s_bit, s_last, s_done, s_zero;
  logic n_rej, n_busy, n_valid, n_bit, n_last, n_done, n_zero;
  logic o_rej, o_busy, o_valid, o_bit, o_last, o_done, o_zero;
  int   sel = 0;

  always #5 clock = ~clock;

  exp_stream_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_WORDS(4), .OUT_REG(1), .SKIP_LZ(1)) dut_s (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_reject(s_rej), .start(start), .busy(s_busy), .bit_valid(s_valid), .bit_out(s_bit),
    .bit_last(s_last), .bit_ready(bit_ready), .done(s_done), .zero_exp(s_zero));

  exp_stream_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_WORDS(4), .OUT_REG(0), .SKIP_LZ(0)) dut_n (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_reject(n_rej), .start(start), .busy(n_busy), .bit_valid(n_valid), .bit_out(n_bit),
    .bit_last(n_last), .bit_ready(bit_ready), .done(n_done), .zero_exp(n_zero));

  always_comb begin
    if (sel == 0) {o_rej, o_busy, o_valid, o_bit, o_last, o_done, o_zero} = {s_rej, s_busy, s_valid, s_bit, s_last, s_done, s_zero};
    else          {o_rej, o_busy, o_valid, o_bit, o_last, o_done, o_zero} = {n_rej, n_busy, n_valid, n_bit, n_last, n_done, n_zero};
  end

  int tests = 0, fails = 0;
  logic [63:0] got;
  int ng, first_v, last_cnt, last_pos, last_x, done_c, stall_err, valid_seen, bubbles, rej;
  logic zx, busy_at_done, busy_after, done_after, zero_after;
  logic [18:0] exp19;

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    @(negedge clock); wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clock); wr_en = 1'b0;
  endtask

  // Starts a scan and collects the stream of the selected instance.
  task automatic run_scan(input int rmode, input int abort_n, input int poke_at,
                          input bit wr_w3, input bit start_on_done);
    bit fin, aborted, pstall, pb, pl;
    fin = 0; aborted = 0; pstall = 0; pb = 0; pl = 0;
    ng = 0; got = '0; first_v = -1; last_cnt = 0; last_pos = -1; last_x = -1; done_c = -1;
    stall_err = 0; valid_seen = 0; bubbles = 0; rej = 0; zx = 0;
    busy_at_done = 1; busy_after = 1; done_after = 1; zero_after = 0;
    @(negedge clock);
    bit_ready = 1'b1; start = 1'b1;
    if (wr_w3) begin wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h80; end
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      @(negedge clock);
      start = 1'b0; wr_en = 1'b0;
      if (o_rej) rej++;
      if (pstall && (o_valid !== 1'b1 || o_bit !== pb || o_last !== pl)) stall_err++;
      pstall = 0;
      if (o_done) begin
        done_c = cyc; zx = o_zero; busy_at_done = o_busy; fin = 1;
        if (start_on_done) start = 1'b1;
      end else begin
        if (o_valid) begin valid_seen++; if (first_v < 0) first_v = cyc; end
        else if (first_v >= 0) bubbles++;
        if (cyc == poke_at) begin wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hFF; start = 1'b1; end
        bit_ready = (rmode == 0) ? 1'b1 : cyc[0];
        pstall = o_valid && !bit_ready; pb = o_bit; pl = o_last;
        if (o_valid && bit_ready) begin
          got = {got[62:0], o_bit}; ng++; last_x = cyc;
          if (o_last) begin last_cnt++; last_pos = ng; end
          if (abort_n != 0 && ng == abort_n) begin fin = 1; aborted = 1; end
        end
      end
    end
    tests++;
    if (!fin) begin fails++; $display("FAIL scan_timeout no done within 400 cycles"); end
    if (aborted) begin
      @(posedge clock); #2;
    end else begin
      @(negedge clock);
      start = 1'b0; bit_ready = 1'b1;
      done_after = o_done; busy_after = o_busy; zero_after = o_zero;
      for (int i = 0; i < 200 && (s_busy || n_busy); i++) @(negedge clock);
      tests++;
      if (s_busy || n_busy) begin fails++; $display("FAIL drain_timeout busy s=%b n=%b", s_busy, n_busy); end
    end
    bit_ready = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({s_rej, s_busy, s_valid, s_bit, s_last, s_done, s_zero} !== 7'd0) begin
      fails++; $display("FAIL reset_s outputs=%b exp 0000000", {s_rej, s_busy, s_valid, s_bit, s_last, s_done, s_zero});
    end
    tests++;
    if ({n_rej, n_busy, n_valid, n_bit, n_last, n_done, n_zero} !== 7'd0) begin
      fails++; $display("FAIL reset_n outputs=%b exp 0000000", {n_rej, n_busy, n_valid, n_bit, n_last, n_done, n_zero});
    end
    @(negedge clock); reset_n = 1'b1;
  endtask

  task automatic test_basic();
    load(2'd3, 8'h00); load(2'd2, 8'h05); load(2'd1, 8'hA0); load(2'd0, 8'h01);
    sel = 0;
    run_scan(0, 0, 0, 0, 1);
    tests++; if (ng !== 19) begin fails++; $display("FAIL t1_count got %0d exp 19", ng); end
    tests++; if (got[18:0] !== exp19) begin fails++; $display("FAIL t1_bits got %b exp %b", got[18:0], exp19); end
    tests++; if (last_cnt !== 1 || last_pos !== 19) begin fails++; $display("FAIL t1_last cnt %0d pos %0d exp 1/19", last_cnt, last_pos); end
    tests++; if (done_c !== last_x + 1) begin fails++; $display("FAIL t1_done_cycle got %0d exp %0d", done_c, last_x + 1); end
    tests++; if (busy_at_done !== 1'b0) begin fails++; $display("FAIL t1_busy_at_done got %b exp 0", busy_at_done); end
    tests++; if (zx !== 1'b0) begin fails++; $display("FAIL t1_zero_exp got %b exp 0", zx); end
    tests++; if (bubbles !== 0) begin fails++; $display("FAIL t1_bubbles got %0d exp 0", bubbles); end
    tests++; if (busy_after !== 1'b0 || done_after !== 1'b0) begin
      fails++; $display("FAIL t1_start_in_done busy %b done %b exp 0/0", busy_after, done_after);
    end
  endtask

  task automatic test_stall();
    sel = 0;
    run_scan(1, 0, 0, 0, 0);
    tests++; if (ng !== 19) begin fails++; $display("FAIL t2_count got %0d exp 19", ng); end
    tests++; if (got[18:0] !== exp19) begin fails++; $display("FAIL t2_bits got %b exp %b", got[18:0], exp19); end
    tests++; if (stall_err !== 0) begin fails++; $display("FAIL t2_stall_stable errors %0d exp 0", stall_err); end
    tests++; if (last_pos !== 19) begin fails++; $display("FAIL t2_last pos %0d exp 19", last_pos); end
    sel = 1;
    run_scan(1, 0, 0, 0, 0);
    tests++; if (stall_err !== 0) begin fails++; $display("FAIL t2n_stall_stable errors %0d exp 0", stall_err); end
    tests++; if (ng !== 32 || got[31:0] !== 32'h0005A001) begin fails++; $display("FAIL t2n_bits got %0d/%h exp 32/0005a001", ng, got[31:0]); end
  endtask

  task automatic test_reject();
    sel = 0;
    run_scan(0, 0, 10, 0, 0);
    tests++; if (rej !== 1) begin fails++; $display("FAIL t4_reject pulses %0d exp 1", rej); end
    tests++; if (ng !== 19 || got[18:0] !== exp19) begin fails++; $display("FAIL t4_scan_bits got %b exp %b", got[18:0], exp19); end
    run_scan(0, 0, 0, 0, 0);
    tests++; if (ng !== 19 || got[18:0] !== exp19) begin fails++; $display("FAIL t4_rescan_bits got %b exp %b", got[18:0], exp19); end
  endtask

  task automatic test_abort();
    sel = 0;
    run_scan(0, 7, 0, 0, 0);
    tests++; if (got[6:0] !== 7'b1011010) begin fails++; $display("FAIL t5_prefix got %b exp 1011010", got[6:0]); end
    reset_n = 1'b0;
    #1;
    tests++;
    if ({s_rej, s_busy, s_valid, s_bit, s_last, s_done, s_zero} !== 7'd0) begin
      fails++; $display("FAIL t5_async_reset outputs=%b exp 0000000", {s_rej, s_busy, s_valid, s_bit, s_last, s_done, s_zero});
    end
    @(negedge clock); reset_n = 1'b1;
    run_scan(0, 0, 0, 0, 0);
    tests++; if (ng !== 19 || got[18:0] !== exp19) begin fails++; $display("FAIL t5_rescan got %0d/%b exp 19/%b", ng, got[18:0], exp19); end
  endtask

  task automatic test_zero();
    load(2'd3, 8'h00); load(2'd2, 8'h00); load(2'd1, 8'h00); load(2'd0, 8'h00);
    sel = 0;
    run_scan(0, 0, 0, 0, 0);
    tests++; if (valid_seen !== 0) begin fails++; $display("FAIL t3_no_valid got %0d exp 0", valid_seen); end
    tests++; if (zx !== 1'b1 || done_c < 0) begin fails++; $display("FAIL t3_zero_exp got %b done %0d exp 1", zx, done_c); end
    tests++; if (zero_after !== 1'b1) begin fails++; $display("FAIL t3_zero_hold got %b exp 1", zero_after); end
    sel = 1;
    run_scan(0, 0, 0, 0, 0);
    tests++; if (ng !== 32 || got[31:0] !== 32'h0) begin fails++; $display("FAIL t3n_bits got %0d/%h exp 32/0", ng, got[31:0]); end
    tests++; if (last_cnt !== 1 || last_pos !== 32) begin fails++; $display("FAIL t3n_last cnt %0d pos %0d exp 1/32", last_cnt, last_pos); end
    tests++; if (done_c !== last_x + 1 || zx !== 1'b0) begin fails++; $display("FAIL t3n_done cyc %0d exp %0d zero %b", done_c, last_x + 1, zx); end
  endtask

  task automatic test_first_valid();
    sel = 0;
    run_scan(0, 0, 0, 1, 0);
    tests++; if (first_v !== 4) begin fails++; $display("FAIL t6_first_valid_oreg1 got %0d exp 4", first_v); end
    tests++; if (valid_seen !== 32 || bubbles !== 0) begin fails++; $display("FAIL t6_stream_oreg1 valid %0d bubbles %0d exp 32/0", valid_seen, bubbles); end
    tests++; if (got[31:0] !== 32'h80000000 || zx !== 1'b0) begin fails++; $display("FAIL t6_bits_oreg1 got %h zero %b exp 80000000/0", got[31:0], zx); end
    sel = 1;
    run_scan(0, 0, 0, 0, 0);
    tests++; if (first_v !== 3) begin fails++; $display("FAIL t6_first_valid_oreg0 got %0d exp 3", first_v); end
    tests++; if (valid_seen !== 32 || bubbles !== 0) begin fails++; $display("FAIL t6_stream_oreg0 valid %0d bubbles %0d exp 32/0", valid_seen, bubbles); end
    tests++; if (got[31:0] !== 32'h80000000 || last_pos !== 32) begin fails++; $display("FAIL t6_bits_oreg0 got %h last %0d exp 80000000/32", got[31:0], last_pos); end
  endtask

  initial begin
    exp19 = {3'b101, 8'hA0, 8'h01};
    test_reset();
    test_basic();
    test_stall();
    test_reject();
    test_abort();
    test_zero();
    test_first_valid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
